// File: rtl/lvt_mpram.sv
// Multi-ported RAM: NWR x NRD single-write/single-read banks plus a Live Value Table
// that records, per address, whether it was written and by which write port.
module lvt_mpram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int NWR    = 2,
  parameter int NRD    = 2,
  parameter int BYPASS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_valid,
  output logic [15:0]           conflict_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IDX_W = (NWR > 1) ? $clog2(NWR) : 1;

  logic [DATA_W-1:0] bank [NWR][NRD][DEPTH];
  logic [DEPTH-1:0]  lvt_written;
  logic [IDX_W-1:0]  lvt_idx [DEPTH];

  logic [ADDR_W-1:0] wa [NWR];
  logic [DATA_W-1:0] wd [NWR];
  logic [ADDR_W-1:0] ra [NRD];
  logic [DATA_W-1:0] rd_next [NRD];
  logic              conflict;

  always_comb begin
    for (int w = 0; w < NWR; w++) begin
      wa[w] = wr_addr[w*ADDR_W +: ADDR_W];
      wd[w] = wr_data[w*DATA_W +: DATA_W];
    end
    for (int r = 0; r < NRD; r++) begin
      ra[r] = rd_addr[r*ADDR_W +: ADDR_W];
    end
  end

  // NOTE: bank storage has no reset so it maps onto RAM primitives; the LVT
  // written flags alone make reset-cleared contents observable.
  always_ff @(posedge clk) begin
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w]) begin
        for (int r = 0; r < NRD; r++) begin
          bank[w][r][wa[w]] <= wd[w];
        end
      end
    end
  end

  // NOTE: non-blocking updates in ascending port order mean the last (highest
  // index) enabled writer to an address is the one that lands in the LVT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvt_written <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        lvt_idx[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w]) begin
          lvt_written[wa[w]] <= 1'b1;
          lvt_idx[wa[w]]     <= IDX_W'(w);
        end
      end
    end
  end

  // NOTE: every always_comb output gets a default before any condition so no
  // path leaves it unassigned (no latches).
  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      rd_next[r] = '0;
      if (lvt_written[ra[r]]) begin
        rd_next[r] = bank[lvt_idx[ra[r]]][r][ra[r]];
      end
      if (BYPASS != 0) begin
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && (wa[w] == ra[r])) begin
            rd_next[r] = wd[w];
          end
        end
      end
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wr_en[i] && wr_en[j] && (wa[i] == wa[j])) begin
          conflict = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      rd_valid <= rd_en;
      for (int r = 0; r < NRD; r++) begin
        if (rd_en[r]) begin
          rd_data[r*DATA_W +: DATA_W] <= rd_next[r];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule
